// File: rtl/hash_in_arbiter.sv
// hash_in_arbiter
// Round-robin arbiter and framer in front of the shared SHA3 input FIFO.
// One core is granted at a time. Its 256-bit result is latched into a local
// buffer and sent as a 5-word packet: a header word, then the four 64-bit
// data words, least significant word first. A high fifo_full stalls the
// packet for that edge without losing or repeating a word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet in flight; capture the round-robin winner if any
// HDR   | header word is next to be written
// W0    | data bits [63:0] are next to be written
// W1    | data bits [127:64] are next to be written
// W2    | data bits [191:128] are next to be written
// W3    | data bits [255:192] are next; a pending request is captured on
//       | the same edge so packets run back to back with no gap
module hash_in_arbiter #(
  parameter int          N_REQ  = 4,
  parameter logic [63:0] HEADER = 64'h8000000000000100,
  localparam int         IW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [256*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]     req_ack,
  input  logic                 fifo_full,
  output logic                 we_out,
  output logic [63:0]          dout,
  output logic                 busy,
  output logic [IW-1:0]        grant_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_W0,
    S_W1,
    S_W2,
    S_W3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      rr_ptr_nxt;
  logic [255:0]       data_buf;
  logic [255:0]       data_buf_nxt;
  logic [IW-1:0]      grant_nxt;
  logic [N_REQ-1:0]   ack_nxt;
  logic               we_nxt;
  logic [63:0]        dout_nxt;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic               capture;

  // Winner search: first valid request starting at rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + off) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(rr_ptr) + off) % N_REQ);
      end
    end
  end

  // A capture needs a free buffer: either nothing is in flight, or the last
  // word leaves on this very edge (W3 written, not stalled).
  assign capture = win_found &&
                   ((state == S_IDLE) || ((state == S_W3) && !fifo_full));

  // Next-state, emission and capture decode.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    data_buf_nxt = data_buf;
    grant_nxt    = grant_idx;
    ack_nxt      = '0;
    we_nxt       = 1'b0;
    dout_nxt     = dout;

    case (state)
      S_IDLE: begin
        state_nxt = S_IDLE;
      end
      S_HDR: begin
        if (!fifo_full) begin
          we_nxt    = 1'b1;
          dout_nxt  = HEADER;
          state_nxt = S_W0;
        end
      end
      S_W0: begin
        if (!fifo_full) begin
          we_nxt    = 1'b1;
          dout_nxt  = data_buf[63:0];
          state_nxt = S_W1;
        end
      end
      S_W1: begin
        if (!fifo_full) begin
          we_nxt    = 1'b1;
          dout_nxt  = data_buf[127:64];
          state_nxt = S_W2;
        end
      end
      S_W2: begin
        if (!fifo_full) begin
          we_nxt    = 1'b1;
          dout_nxt  = data_buf[191:128];
          state_nxt = S_W3;
        end
      end
      S_W3: begin
        if (!fifo_full) begin
          we_nxt    = 1'b1;
          dout_nxt  = data_buf[255:192];
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The W3 word above is taken from the old buffer, so overwriting the
    // buffer on the same edge is safe.
    if (capture) begin
      data_buf_nxt     = req_data[int'(win_idx)*256 +: 256];
      grant_nxt        = win_idx;
      ack_nxt[win_idx] = 1'b1;
      if (win_idx == IW'(N_REQ - 1)) begin
        rr_ptr_nxt = '0;
      end else begin
        rr_ptr_nxt = win_idx + 1'b1;
      end
      state_nxt = S_HDR;
    end
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      data_buf  <= '0;
      grant_idx <= '0;
      req_ack   <= '0;
      we_out    <= 1'b0;
      dout      <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      data_buf  <= data_buf_nxt;
      grant_idx <= grant_nxt;
      req_ack   <= ack_nxt;
      we_out    <= we_nxt;
      dout      <= dout_nxt;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_hash_in_arbiter.sv
// Self-checking bench for hash_in_arbiter: expected words and grants are
// queued as requests are presented and compared against what the DUT writes.
module tb_hash_in_arbiter;

  localparam int          N   = 4;
  localparam logic [63:0] HDR = 64'h8000000000000100;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [256*N-1:0] req_data;
  logic [N-1:0]     req_ack;
  logic             fifo_full;
  logic             we_out;
  logic [63:0]      dout;
  logic             busy;
  logic [1:0]       grant_idx;

  hash_in_arbiter #(.N_REQ(N), .HEADER(HDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .fifo_full (fifo_full),
    .we_out    (we_out),
    .dout      (dout),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  // Edge counter, used to time-stamp observed writes and acks.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0]  obs_w[$];
  int           obs_wc[$];
  logic [N-1:0] obs_a[$];
  logic [1:0]   obs_g[$];
  int           obs_ac[$];
  logic [63:0]  exp_w[$];
  int           exp_g[$];

  int left[N];
  int core_cnt[N];
  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] mk_word(int i, int n, int j);
    return {8'(8'hC0 + i), 8'(n), 8'(j), 40'h13579BDF02};
  endfunction

  function automatic logic [255:0] mk_res(int i, int n);
    return {mk_word(i, n, 3), mk_word(i, n, 2), mk_word(i, n, 1), mk_word(i, n, 0)};
  endfunction

  task automatic push_pkt(int i, int n);
    exp_w.push_back(HDR);
    for (int j = 0; j < 4; j++) exp_w.push_back(mk_word(i, n, j));
    exp_g.push_back(i);
  endtask

  task automatic present(int i, int cnt);
    left[i] = cnt;
    req_data[256*i +: 256] = mk_res(i, core_cnt[i]);
    req_valid[i] = 1'b1;
  endtask

  // One cycle: record DUT activity at the negedge, then let cores react to acks.
  task automatic step();
    @(negedge clk);
    if (we_out) begin
      obs_w.push_back(dout);
      obs_wc.push_back(cyc);
    end
    if (req_ack != '0) begin
      obs_a.push_back(req_ack);
      obs_g.push_back(grant_idx);
      obs_ac.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        core_cnt[i]++;
        left[i]--;
        if (left[i] <= 0) req_valid[i] = 1'b0;
        else req_data[256*i +: 256] = mk_res(i, core_cnt[i]);
      end
    end
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_wc.delete(); obs_a.delete(); obs_g.delete();
    obs_ac.delete(); exp_w.delete(); exp_g.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      core_cnt[i] = 0;
      left[i] = 0;
    end
    clear_obs();
  endtask

  task automatic wait_words(int n, int budget);
    for (int c = 0; c < budget && obs_w.size() < n; c++) step();
  endtask

  task automatic wait_ack(int budget);
    for (int c = 0; c < budget && obs_a.size() == 0; c++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    step();
    step();
    total++; if (we_out !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we_out); end
    total++; if (dout !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if (req_ack !== '0) begin bad++; $display("FAIL reset_ack got=%b want=0", req_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_idx); end
    do_reset();
  endtask

  task automatic test_single();
    logic [63:0] e, o;
    int g;
    do_reset();
    push_pkt(2, 0);
    present(2, 1);
    wait_ack(10);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    wait_words(5, 20);
    step();
    step();
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL single_ackcnt got=%0d want=1", obs_a.size()); end
    total++; if (obs_wc.size() < 5 || obs_ac.size() < 1 || obs_wc[0] != obs_ac[0] + 1 || obs_wc[4] != obs_wc[0] + 4)
      begin bad++; $display("FAIL single_timing got_first=%0d got_last=%0d", obs_wc.size() > 0 ? obs_wc[0] : -1, obs_wc.size() > 4 ? obs_wc[4] : -1); end
    total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL single_word got=%h want=%h", o, e); end
    end
    while (exp_g.size() > 0 && obs_a.size() > 0) begin
      g = exp_g.pop_front();
      total++; if (obs_a.pop_front() !== N'(1 << g) || obs_g.pop_front() !== 2'(g))
        begin bad++; $display("FAIL single_grant want=%0d", g); end
    end
    total++; if (grant_idx !== 2'd2) begin bad++; $display("FAIL single_grant_hold got=%0d want=2", grant_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [63:0] e, o;
    int g;
    do_reset();
    push_pkt(0, 0); push_pkt(1, 0); push_pkt(2, 0); push_pkt(3, 0); push_pkt(0, 1);
    present(0, 2); present(1, 1); present(2, 1); present(3, 1);
    wait_words(20, 80);
    total++; if (obs_w.size() != 20) begin bad++; $display("FAIL rr_count got=%0d want=20", obs_w.size()); end
    total++; if (obs_wc.size() < 20 || obs_wc[19] - obs_wc[0] != 19)
      begin bad++; $display("FAIL rr_gap got_span=%0d want=19", obs_wc.size() >= 20 ? obs_wc[19] - obs_wc[0] : -1); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rr_word got=%h want=%h", o, e); end
    end
    total++; if (obs_a.size() != 5) begin bad++; $display("FAIL rr_ackcnt got=%0d want=5", obs_a.size()); end
    while (exp_g.size() > 0 && obs_a.size() > 0) begin
      g = exp_g.pop_front();
      total++; if (obs_a.pop_front() !== N'(1 << g) || obs_g.pop_front() !== 2'(g))
        begin bad++; $display("FAIL rr_grant want=%0d", g); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e, o;
    do_reset();
    push_pkt(1, 0);
    present(1, 1);
    wait_ack(10);
    step();
    step();
    fifo_full = 1'b1;
    step(); step(); step();
    fifo_full = 1'b0;
    total++; if (obs_w.size() != 2) begin bad++; $display("FAIL bp_stall_writes got=%0d want=2", obs_w.size()); end
    wait_words(5, 20);
    total++; if (obs_wc.size() < 5 || obs_wc[4] - obs_wc[0] != 7 || obs_wc[2] - obs_wc[1] != 4)
      begin bad++; $display("FAIL bp_span got=%0d want=7", obs_wc.size() >= 5 ? obs_wc[4] - obs_wc[0] : -1); end
    total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL bp_word got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_wrap_skip();
    logic [63:0] e, o;
    logic [N-1:0] ack_or;
    int g;
    do_reset();
    present(2, 1);
    wait_words(5, 20);
    step();
    clear_obs();
    push_pkt(3, 0); push_pkt(1, 0);
    present(1, 1); present(3, 1);
    wait_words(10, 40);
    step();
    ack_or = '0;
    foreach (obs_a[k]) ack_or |= obs_a[k];
    total++; if ((ack_or & 4'b0101) !== 4'b0000) begin bad++; $display("FAIL wrap_noack got=%b want=0000", ack_or & 4'b0101); end
    total++; if (obs_a.size() != 2) begin bad++; $display("FAIL wrap_ackcnt got=%0d want=2", obs_a.size()); end
    while (exp_g.size() > 0 && obs_a.size() > 0) begin
      g = exp_g.pop_front();
      total++; if (obs_a.pop_front() !== N'(1 << g) || obs_g.pop_front() !== 2'(g))
        begin bad++; $display("FAIL wrap_grant want=%0d", g); end
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wrap_word got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e, o;
    do_reset();
    present(3, 1);
    wait_ack(10);
    step();
    step();
    rst = 1'b1;
    step();
    total++; if (we_out !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", we_out); end
    total++; if (dout !== 64'h0) begin bad++; $display("FAIL rmid_dout got=%h want=0", dout); end
    total++; if (req_ack !== '0) begin bad++; $display("FAIL rmid_ack got=%b want=0", req_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) step();
    total++; if (obs_w.size() != 2) begin bad++; $display("FAIL rmid_nowrite got=%0d want=2", obs_w.size()); end
    clear_obs();
    push_pkt(3, 1);
    present(3, 1);
    wait_words(5, 20);
    total++; if (obs_w.size() != 5) begin bad++; $display("FAIL rmid_fresh_count got=%0d want=5", obs_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rmid_word got=%h want=%h", o, e); end
    end
    total++; if (grant_idx !== 2'd3) begin bad++; $display("FAIL rmid_grant got=%0d want=3", grant_idx); end
  endtask

  task automatic test_stall_w3();
    logic [63:0] e, o;
    int g;
    do_reset();
    push_pkt(0, 0); push_pkt(1, 0);
    present(0, 1); present(1, 1);
    wait_ack(10);
    step(); step(); step(); step();
    fifo_full = 1'b1;
    step(); step();
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL w3_noack got=%0d want=1", obs_a.size()); end
    total++; if (obs_w.size() != 4) begin bad++; $display("FAIL w3_stall_writes got=%0d want=4", obs_w.size()); end
    fifo_full = 1'b0;
    wait_words(10, 40);
    total++; if (obs_ac.size() < 2 || obs_wc.size() < 6 || obs_ac[1] != obs_wc[4] || obs_wc[5] != obs_wc[4] + 1)
      begin bad++; $display("FAIL w3_capture_edge got_ack=%0d want=%0d", obs_ac.size() > 1 ? obs_ac[1] : -1, obs_wc.size() > 4 ? obs_wc[4] : -1); end
    total++; if (obs_ac.size() < 2 || obs_ac[1] - obs_ac[0] != 7)
      begin bad++; $display("FAIL w3_spacing got=%0d want=7", obs_ac.size() > 1 ? obs_ac[1] - obs_ac[0] : -1); end
    while (exp_g.size() > 0 && obs_a.size() > 0) begin
      g = exp_g.pop_front();
      total++; if (obs_a.pop_front() !== N'(1 << g) || obs_g.pop_front() !== 2'(g))
        begin bad++; $display("FAIL w3_grant want=%0d", g); end
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL w3_word got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_stall_w3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
